// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL lock-driven core/peripheral reset sequencer (optional PLL_RST_SEQ_LOSS_CNT_EN)
module pll_rst_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_WAIT   = 1024,
   parameter int STAGE_GAP   = 16,
   parameter int CNT_W       = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       pll_lock_i,
   input  logic       soft_rst_i,
   input  logic       clr_i,
   output logic       rst_core_o,
   output logic       rst_periph_o,
   output logic       ready_o,
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   output logic [7:0] loss_cnt_o,
`endif
   output logic       lock_lost_o
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      REL_CORE  = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;
   logic                   loss_evt;

   assign lock_s = sync_q[SYNC_STAGES-1];

   // A soft re-sequence outranks lock loss, so it never marks the event as a loss.
   assign loss_evt = !soft_rst_i && !lock_s && ((state == REL_CORE) || (state == RUN));

   // Bring the asynchronous PLL lock flag into the clock domain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
      end
   end

   // Sequencer: wait for stable lock, release core, then peripherals; fall back on loss or soft request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         rst_core_o   <= 1'b1;
         rst_periph_o <= 1'b1;
         ready_o      <= 1'b0;
         lock_lost_o  <= 1'b0;
      end else begin
         if (loss_evt) begin
            lock_lost_o <= 1'b1;
         end else if (clr_i) begin
            lock_lost_o <= 1'b0;
         end

         if (soft_rst_i || loss_evt) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            rst_core_o   <= 1'b1;
            rst_periph_o <= 1'b1;
            ready_o      <= 1'b0;
         end else begin
            case (state)
               WAIT_LOCK: begin
                  cnt <= '0;
                  if (lock_s) begin
                     state <= STABLE;
                  end
               end
               STABLE: begin
                  if (!lock_s) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else if (cnt == LOCK_LAST) begin
                     state      <= REL_CORE;
                     cnt        <= '0;
                     rst_core_o <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               REL_CORE: begin
                  if (cnt == GAP_LAST) begin
                     state        <= RUN;
                     rst_periph_o <= 1'b0;
                     ready_o      <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RUN: begin
                  state <= RUN;
               end
               default: begin
                  state        <= WAIT_LOCK;
                  cnt          <= '0;
                  rst_core_o   <= 1'b1;
                  rst_periph_o <= 1'b1;
                  ready_o      <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   // Saturating loss-event counter; a loss coinciding with clear restarts the count at one.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         loss_cnt_o <= 8'd0;
      end else if (loss_evt) begin
         if (clr_i) begin
            loss_cnt_o <= 8'd1;
         end else if (loss_cnt_o != 8'hFF) begin
            loss_cnt_o <= loss_cnt_o + 8'd1;
         end
      end else if (clr_i) begin
         loss_cnt_o <= 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - directed self-checking bench for pll_rst_seq
module tb_pll_rst_seq;

   logic       clk;
   logic       rst;
   logic       pll_lock;
   logic       soft_rst;
   logic       clr;
   logic       rst_core;
   logic       rst_periph;
   logic       ready;
   logic       lock_lost;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   logic [7:0] loss_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   pll_rst_seq #(
      .SYNC_STAGES(2),
      .LOCK_WAIT  (8),
      .STAGE_GAP  (4),
      .CNT_W      (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .pll_lock_i  (pll_lock),
      .soft_rst_i  (soft_rst),
      .clr_i       (clr),
      .rst_core_o  (rst_core),
      .rst_periph_o(rst_periph),
      .ready_o     (ready),
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      .loss_cnt_o  (loss_cnt),
`endif
      .lock_lost_o (lock_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic c, input logic p, input logic r, input logic l);
      chk({tag, ".rst_core"}, {7'd0, rst_core}, {7'd0, c});
      chk({tag, ".rst_periph"}, {7'd0, rst_periph}, {7'd0, p});
      chk({tag, ".ready"}, {7'd0, ready}, {7'd0, r});
      chk({tag, ".lock_lost"}, {7'd0, lock_lost}, {7'd0, l});
   endtask

   // Step edges 1..ready_at, checking the reset release schedule after each edge.
   task automatic seq_up(input string tag, input int core_at, input int ready_at);
      for (int e = 1; e <= ready_at; e++) begin
         tick();
         chk($sformatf("%s.core@%0d", tag, e), {7'd0, rst_core}, {7'd0, (e < core_at)});
         chk($sformatf("%s.periph@%0d", tag, e), {7'd0, rst_periph}, {7'd0, (e < ready_at)});
         chk($sformatf("%s.ready@%0d", tag, e), {7'd0, ready}, {7'd0, (e >= ready_at)});
      end
   endtask

   task automatic do_loss(input string tag);
      pll_lock = 1'b0;
      tick();
      tick();
      chk({tag, ".still_ready"}, {7'd0, ready}, 8'd1);
      tick();
      chk_outs({tag, ".lost"}, 1'b1, 1'b1, 1'b0, 1'b1);
      pll_lock = 1'b1;
      seq_up({tag, ".relock"}, 11, 15);
   endtask

   initial begin
      rst      = 1'b1;
      pll_lock = 1'b1;
      soft_rst = 1'b0;
      clr      = 1'b0;

      // T1: reset held with lock high
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_outs("t1.rst", 1'b1, 1'b1, 1'b0, 1'b0);
      end
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      chk("t1.loss_cnt", loss_cnt, 8'd0);
`endif
      rst = 1'b0;

      // T2: power-up sequence
      seq_up("t2", 11, 15);
      chk("t2.lock_lost", {7'd0, lock_lost}, 8'd0);

      // T4: lock loss in RUN, relock, clear
      do_loss("t4");
      chk("t4.lost_kept", {7'd0, lock_lost}, 8'd1);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      chk("t4.loss_cnt", loss_cnt, 8'd1);
`endif
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk_outs("t4.clr", 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      chk("t4.loss_cnt_clr", loss_cnt, 8'd0);
`endif

      // T5: soft re-sequence pulse with lock held
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      chk_outs("t5.soft", 1'b1, 1'b1, 1'b0, 1'b0);
      seq_up("t5", 9, 13);

      // T3: one-cycle lock glitch while STABLE at cnt=5 restarts the count
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      seq_up("t3", 11, 15);
      chk("t3.lock_lost", {7'd0, lock_lost}, 8'd0);

      // T6: repeated losses, then clear coincident with a loss
      do_loss("t6a");
      do_loss("t6b");
      do_loss("t6c");
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      chk("t6.loss_cnt3", loss_cnt, 8'd3);
`endif
      pll_lock = 1'b0;
      tick();
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk_outs("t6.clr_loss", 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      chk("t6.loss_cnt1", loss_cnt, 8'd1);
`endif
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t6.clr_only", {7'd0, lock_lost}, 8'd0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
      chk("t6.loss_cnt0", loss_cnt, 8'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
